// File: rtl/red_arbiter.sv
// Round-robin front end sharing one sequential GF(2^m) reduction unit between NUM_REQ requesters.
// Latency: accept edge T -> red_op_enable from T+1; finish seen in F -> rsp_valid in F+1, next accept >= F+2.
// Backpressure: req_ready only in IDLE, one-hot to the round-robin winner; requesters hold valid+payload until ready.
module red_arbiter #(
    parameter int DATA_WIDTH = 8,
    parameter int NUM_REQ    = 2,
    parameter int GW         = $clog2(DATA_WIDTH) + 1
) (
    input  logic                               clk,
    input  logic                               rst_n,
    input  logic [NUM_REQ-1:0]                 req_valid,
    output logic [NUM_REQ-1:0]                 req_ready,
    input  logic [NUM_REQ*GW-1:0]              req_grade,
    input  logic [NUM_REQ*(DATA_WIDTH+1)-1:0]  req_polyn,
    input  logic [NUM_REQ*2*DATA_WIDTH-1:0]    req_data,
    output logic [NUM_REQ-1:0]                 rsp_valid,
    output logic [DATA_WIDTH-1:0]              rsp_data,
    output logic                               rsp_err,
    output logic                               busy,
    output logic                               red_op_enable,
    output logic [GW-1:0]                      red_polyn_grade,
    output logic [DATA_WIDTH:0]                red_polyn_red_in,
    output logic [2*DATA_WIDTH-1:0]            red_reduc_in,
    input  logic [DATA_WIDTH-1:0]              red_out,
    input  logic                               red_op_finish
);
    localparam int IW = $clog2(NUM_REQ);
    localparam int PW = DATA_WIDTH + 1;
    localparam int DW2 = 2 * DATA_WIDTH;
    localparam logic [IW-1:0]      LAST_IDX  = IW'(NUM_REQ - 1);
    localparam logic [IW:0]        NUM_REQ_W = (IW+1)'(NUM_REQ);
    localparam logic [GW-1:0]      MAX_GRADE = GW'(DATA_WIDTH);
    localparam logic [NUM_REQ-1:0] ONE_HOT0  = NUM_REQ'(1);

    typedef enum logic [1:0] {IDLE, RUN, DONE, ERR} state_t;

    state_t              state;
    logic [IW-1:0]       ptr;
    logic [IW-1:0]       gnt_q;
    logic [IW-1:0]       pick;
    logic                pick_vld;
    logic [IW:0]         scan;
    logic [NUM_REQ-1:0]  pick_onehot;
    logic [GW-1:0]       pick_grade;
    logic [PW-1:0]       pick_polyn;
    logic [DW2-1:0]      pick_data;
    logic                grade_bad;

    // Round-robin scan: first valid requester starting at ptr, wrapping modulo NUM_REQ.
    always_comb begin
        pick     = ptr;
        pick_vld = 1'b0;
        scan     = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            scan = {1'b0, ptr} + (IW+1)'(k);
            if (scan >= NUM_REQ_W) begin
                scan = scan - NUM_REQ_W;
            end
            if (!pick_vld && req_valid[scan[IW-1:0]]) begin
                pick_vld = 1'b1;
                pick     = scan[IW-1:0];
            end
        end
    end

    assign pick_onehot = ONE_HOT0 << pick;
    assign pick_grade  = req_grade[pick*GW +: GW];
    assign pick_polyn  = req_polyn[pick*PW +: PW];
    assign pick_data   = req_data[pick*DW2 +: DW2];
    assign grade_bad   = (pick_grade == '0) || (pick_grade > MAX_GRADE);

    // Accept only in IDLE; nothing is accepted while reset is held.
    assign req_ready = (rst_n && state == IDLE && pick_vld) ? pick_onehot : '0;
    assign busy      = (state != IDLE);

    // Control FSM: accept, run the reduction unit, emit a one-cycle response, rearm.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state            <= IDLE;
            ptr              <= '0;
            gnt_q            <= '0;
            rsp_valid        <= '0;
            rsp_data         <= '0;
            rsp_err          <= 1'b0;
            red_op_enable    <= 1'b0;
            red_polyn_grade  <= '0;
            red_polyn_red_in <= '0;
            red_reduc_in     <= '0;
        end else begin
            rsp_valid <= '0;
            case (state)
                IDLE: begin
                    if (pick_vld) begin
                        red_polyn_grade  <= pick_grade;
                        red_polyn_red_in <= pick_polyn;
                        red_reduc_in     <= pick_data;
                        gnt_q            <= pick;
                        ptr              <= (pick == LAST_IDX) ? '0 : pick + 1'b1;
                        if (grade_bad) begin
                            // Rejected: respond directly, the reduction unit is never enabled.
                            state     <= ERR;
                            rsp_valid <= pick_onehot;
                            rsp_err   <= 1'b1;
                            rsp_data  <= '0;
                        end else begin
                            state         <= RUN;
                            red_op_enable <= 1'b1;
                            rsp_err       <= 1'b0;
                        end
                    end
                end
                RUN: begin
                    if (red_op_finish) begin
                        state         <= DONE;
                        red_op_enable <= 1'b0;
                        rsp_data      <= red_out;
                        rsp_err       <= 1'b0;
                        rsp_valid     <= ONE_HOT0 << gnt_q;
                    end
                end
                DONE, ERR: begin
                    state   <= IDLE;
                    rsp_err <= 1'b0;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: doc/red_arbiter.md
Name: red_arbiter

Overview:
- Round-robin scheduler that shares one sequential GF(2^m) reduction unit (`red`) between NUM_REQ requesters, e.g. several multiplier cores producing unreduced 2*DATA_WIDTH-bit products.
- Per-requester valid/ready handshake in; one-cycle response strobe with result out.
- Owns `red`'s op_enable sequencing: raises it, waits for op_finish, captures the result, then drops op_enable so `red` rearms.
- Sits between the multiplier array and the single `red` instance.

Parameters:
- DATA_WIDTH, 8, field width m; must match the `red` instance.
- NUM_REQ, 2, number of requesters; legal range 2..4.
- GW, $clog2(DATA_WIDTH)+1, width of the polynomial-grade field (derived; do not override).

Ports:
- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- req_valid  in  NUM_REQ  request pending, one bit per requester
- req_ready  out  NUM_REQ  one-hot accept strobe
- req_grade  in  NUM_REQ*GW  packed grade per requester; slice i at [i*GW +: GW]
- req_polyn  in  NUM_REQ*(DATA_WIDTH+1)  packed reduction polynomial per requester
- req_data  in  NUM_REQ*2*DATA_WIDTH  packed unreduced operand per requester
- rsp_valid  out  NUM_REQ  one-hot, one-cycle response strobe
- rsp_data  out  DATA_WIDTH  result; valid only while any rsp_valid bit is high
- rsp_err  out  1  qualifies rsp_valid; set when the request was rejected
- busy  out  1  high in every state except IDLE
- red_op_enable  out  1  to `red` op_enable
- red_polyn_grade  out  GW  to `red` polyn_grade
- red_polyn_red_in  out  DATA_WIDTH+1  to `red` polyn_red_in
- red_reduc_in  out  2*DATA_WIDTH  to `red` reduc_in
- red_out  in  DATA_WIDTH  from `red` out
- red_op_finish  in  1  from `red` op_finish

Behaviour:
- Reset (async assert, sync release):
  - All outputs and operand registers are 0; state is IDLE.
  - Round-robin pointer is 0, so requester 0 has top priority.
- `red` contract:
  - Operands must be stable while op_enable is high.
  - op_finish rises once the result is ready and stays high while op_enable stays high.
  - op_enable must be low for at least 1 cycle before the next operation.
- IDLE:
  - If any req_valid is high, pick the first set bit scanning from ptr to ptr+NUM_REQ-1 (mod NUM_REQ).
  - Assert req_ready[g] combinationally in that same cycle; the transfer completes on that clock edge.
  - On that edge: latch grade, polyn and data of requester g into the red_* output registers; set ptr to (g+1) mod NUM_REQ.
  - Grade check on the accepted request: grade==0 or grade>DATA_WIDTH -> go to ERR; otherwise go to RUN.
- RUN:
  - red_op_enable=1; red_* operand outputs are held.
  - When red_op_finish==1, capture red_out into rsp_data and go to DONE.
  - No timeout.
- DONE (1 cycle): rsp_valid[g]=1, rsp_err=0, red_op_enable=0; go to IDLE.
- ERR (1 cycle): rsp_valid[g]=1, rsp_err=1, rsp_data=0; `red` is never enabled; go to IDLE.
- Timing:
  - If the accept edge is cycle T, red_op_enable is high from T+1.
  - If finish is seen at cycle F, rsp_valid is high in F+1 and the next accept is no earlier than F+2.
  - This gives at least 2 cycles of op_enable low between operations.
- req_ready is never asserted outside IDLE; requesters hold valid and payload until ready.
- A requester dropping req_valid before it is granted is legal; it is simply skipped.
- Simultaneous requests are served strictly round-robin; no requester waits more than NUM_REQ-1 operations.
- red_op_finish seen in IDLE, DONE or ERR is ignored.
- rst_n asserted mid-RUN: op_enable drops immediately and the in-flight request is lost with no rsp_valid; the requester must reissue it.

Test Plan:
- Single request: requester 0 sends grade=4, polyn=19, data=90 -> req_ready[0] pulses once; rsp_valid[0] pulses once with rsp_data=5, rsp_err=0; red_op_enable is low in the response cycle.
- Back-to-back from requester 1: grade=3, polyn=11, data=27 -> rsp_data=6. Then grade=2, polyn=6, data=7 -> rsp_data=1. red_op_enable is low for at least 2 cycles between the two operations.
- Contention after reset: both requesters valid with the two payloads above -> requester 0 is served first (5), then requester 1 (6). Held valid again -> order 0, 1, 0, 1.
- Invalid grade: grade=0 -> rsp_err=1, rsp_data=0, red_op_enable never rises. Repeat with grade=9 (DATA_WIDTH=8) -> same response.
- Reset mid-RUN: rst_n low 3 cycles after accept -> all outputs 0 immediately and no rsp_valid. After release, the resent request completes correctly and requester 0 again has first priority.
- Stability: while red_op_enable is high, the red_* operand outputs never change, even if req_* inputs toggle.
